mem_stage_lsu: RTL

//  Memory-stage load/store unit. Sits between the EX/MEM and MEM/WB pipeline registers.

---
 rtl/mem_stage_lsu_pkg.sv | 43 ++++
 rtl/mem_stage_lsu_if.sv | 34 +++
 rtl/mem_stage_lsu_align.sv | 59 +++++
 rtl/mem_stage_lsu.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/mem_stage_lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage_lsu_pkg
//  Purpose  : Shared types and constants for the memory-stage load/store unit:
//             FSM state encoding, access-size codes (Funct3[1:0]) and byte-
//             strobe patterns, plus the alignment-fault helper.
//  Revision : 1.0 - initial release
// ============================================================================
package mem_stage_lsu_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } lsu_state_e;

    // Funct3[1:0] access size; Funct3[2] selects zero-extension on loads.
    localparam logic [1:0] c_SZ_B = 2'b00;
    localparam logic [1:0] c_SZ_H = 2'b01;
    localparam logic [1:0] c_SZ_W = 2'b10;

    localparam logic [3:0] c_STRB_B    = 4'b0001;
    localparam logic [3:0] c_STRB_H_LO = 4'b0011;
    localparam logic [3:0] c_STRB_H_HI = 4'b1100;
    localparam logic [3:0] c_STRB_W    = 4'b1111;

    // Halfword at an odd address, or word not on a 4-byte boundary.
    // Size code 2'b11 is treated as a word access.
    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] lane);
        logic r;
        r = 1'b0;
        if (funct3[1:0] == c_SZ_H) begin
            r = lane[0];
        end else if (funct3[1]) begin
            r = (lane != 2'b00);
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_lsu_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage_lsu_if
//  Purpose  : Data-memory bus (req/gnt/rvalid handshake) between the LSU and
//             the memory.
//  Ports    : mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb  (LSU -> mem)
//             mem_gnt, mem_rvalid, mem_rdata                   (mem -> LSU)
//  Modports : master (LSU side), slave (memory side)
//  Revision : 1.0 - initial release
// ============================================================================
interface mem_stage_lsu_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_wstrb;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [DATA_W-1:0]     mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_stage_lsu_align.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage_lsu_align
//  Purpose  : Combinational data formatting for the LSU.
//             Store path: replicate byte/halfword across lanes, build strobes.
//             Load path : pick lane by address, sign/zero extend.
//  Ports    : st_funct3_i, st_lane_i, st_data_i -> st_wdata_o, st_wstrb_o
//             ld_funct3_i, ld_lane_i, ld_rdata_i -> ld_data_o
//  Revision : 1.0 - initial release
// ============================================================================
module mem_stage_lsu_align
    import mem_stage_lsu_pkg::*;
(
    input  logic [2:0]  st_funct3_i,
    input  logic [1:0]  st_lane_i,
    input  logic [31:0] st_data_i,
    output logic [31:0] st_wdata_o,
    output logic [3:0]  st_wstrb_o,
    input  logic [2:0]  ld_funct3_i,
    input  logic [1:0]  ld_lane_i,
    input  logic [31:0] ld_rdata_i,
    output logic [31:0] ld_data_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_sext;

    always_comb begin
        st_wdata_o = st_data_i;
        st_wstrb_o = c_STRB_W;
        case (st_funct3_i[1:0])
            c_SZ_B: begin
                st_wdata_o = {4{st_data_i[7:0]}};
                st_wstrb_o = c_STRB_B << st_lane_i;
            end
            c_SZ_H: begin
                st_wdata_o = {2{st_data_i[15:0]}};
                // Bit 0 is ignored: the halfword lane comes from bit 1 only.
                st_wstrb_o = st_lane_i[1] ? c_STRB_H_HI : c_STRB_H_LO;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_byte    = ld_rdata_i[{ld_lane_i, 3'b000} +: 8];
        w_half    = ld_lane_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];
        w_sext    = ~ld_funct3_i[2];
        ld_data_o = ld_rdata_i;
        case (ld_funct3_i[1:0])
            c_SZ_B:  ld_data_o = {{24{w_sext & w_byte[7]}}, w_byte};
            c_SZ_H:  ld_data_o = {{16{w_sext & w_half[15]}}, w_half};
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage_lsu
//  Purpose  : Memory-stage load/store unit. Runs one bus transaction per
//             load/store in M, stalls the pipeline until the response is
//             captured, then presents formatted load data for MEM/WB.
//  Ports    : clk, rst (async, active high)
//             MemReadM, MemWriteM, Funct3M, ALUResultM, WriteDataM, FlushM
//             bus (mem_stage_lsu_if.master)
//             ReadDataM, StallM, BusErrM
//  Config   : LSU_MISALIGN_TRAP_EN - misaligned H/W accesses fault without
//             touching the bus. Undefined: low address bits are ignored.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemReadM,
    input  logic              MemWriteM,
    input  logic [2:0]        Funct3M,
    input  logic [31:0]       ALUResultM,
    input  logic [31:0]       WriteDataM,
    input  logic              FlushM,
    mem_stage_lsu_if.master   bus,
    output logic [31:0]       ReadDataM,
    output logic              StallM,
    output logic              BusErrM
);

    localparam int             c_CNT_W   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_TMO = c_CNT_W'(TIMEOUT);

    lsu_state_e           state_q;
    logic                 req_q;
    logic                 we_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [DATA_W-1:0]    wdata_q;
    logic [3:0]           wstrb_q;
    logic [2:0]           funct3_q;
    logic [1:0]           lane_q;
    logic [c_CNT_W-1:0]   cnt_q;
    logic [c_CNT_W-1:0]   cnt_d;
    logic [31:0]          rdata_q;
    logic                 err_q;

    logic                 w_op;
    logic                 w_misalign;
    logic [31:0]          w_st_wdata;
    logic [3:0]           w_st_wstrb;
    logic [31:0]          w_ld_data;

    assign w_op  = MemReadM | MemWriteM;
    assign cnt_d = cnt_q + 1'b1;

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = is_misaligned(Funct3M, ALUResultM[1:0]);
`else
    assign w_misalign = 1'b0;
`endif

    // Store data/strobes formatted from the live M-stage inputs (latched on
    // issue); load data formatted from the lane/size latched at issue.
    mem_stage_lsu_align u_align (
        .st_funct3_i (Funct3M),
        .st_lane_i   (ALUResultM[1:0]),
        .st_data_i   (WriteDataM),
        .st_wdata_o  (w_st_wdata),
        .st_wstrb_o  (w_st_wstrb),
        .ld_funct3_i (funct3_q),
        .ld_lane_i   (lane_q),
        .ld_rdata_i  (bus.mem_rdata),
        .ld_data_o   (w_ld_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            funct3_q <= '0;
            lane_q   <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            // Error is a single-cycle pulse aligned with RESP.
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (w_op && !FlushM) begin
                        // A load+store combination is issued as a store.
                        we_q     <= MemWriteM;
                        addr_q   <= {ALUResultM[ADDR_W-1:2], 2'b00};
                        wdata_q  <= w_st_wdata;
                        wstrb_q  <= w_st_wstrb;
                        funct3_q <= Funct3M;
                        lane_q   <= ALUResultM[1:0];
                        if (w_misalign) begin
                            rdata_q <= '0;
                            err_q   <= 1'b1;
                            state_q <= S_RESP;
                        end else begin
                            req_q   <= 1'b1;
                            state_q <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    // Once granted the transaction is committed, so a flush
                    // in the same cycle does not abandon it.
                    if (bus.mem_gnt) begin
                        req_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= S_WAIT;
                    end else if (FlushM) begin
                        req_q   <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (bus.mem_rvalid) begin
                        if (!we_q) begin
                            rdata_q <= w_ld_data;
                        end
                        state_q <= S_RESP;
                    end else if (cnt_q == c_TMO) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        state_q <= S_RESP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_req   = req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_wstrb = wstrb_q;

    assign ReadDataM = rdata_q;
    assign BusErrM   = err_q;
    assign StallM    = w_op & ~FlushM & (state_q != S_RESP);

endmodule
`default_nettype wire
